// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the time-multiplexed sequence detector:
//   det_state_e      - detector state = number of pattern prefix bits matched
//   PATTERN_DEFAULT  - default 4-bit pattern, MSB is the first bit received
//   det_step_t       - {next_state, hit} result of one detector step
//   det_next()       - overlapping Mealy step for an arbitrary 4-bit pattern
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_e;

  localparam logic [3:0] PATTERN_DEFAULT = 4'b1101;

  typedef struct packed {
    det_state_e next_state;
    logic       hit;
  } det_step_t;

  // One detector step. The received history is rebuilt as the matched prefix
  // followed by the new bit (newest bit in the LSB). The next state is the
  // longest suffix of that history which is also a proper prefix of the
  // pattern, so overlapping occurrences are kept.
  function automatic det_step_t det_next(input det_state_e state,
                                         input logic       bit_in,
                                         input logic [3:0] pattern);
    det_step_t  step;
    logic [4:0] hist;
    logic [4:0] mask;
    logic [4:0] pre;
    int         matched;
    matched         = int'(state);
    hist            = {1'b0, pattern} >> (4 - matched);
    hist            = {hist[3:0], bit_in};
    step.hit        = (matched == 3) && (hist[3:0] == pattern);
    step.next_state = S0;
    // Ascending scan: the last match wins, which is the longest one.
    for (int len = 1; len <= 3; len++) begin
      mask = 5'((1 << len) - 1);
      pre  = {1'b0, pattern} >> (4 - len);
      if ((len <= matched + 1) && ((hist & mask) == pre)) begin
        step.next_state = det_state_e'(2'(len));
      end
    end
    return step;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// -----------------------------------------------------------------------------
// seq_det_core
// Purely combinational shared detector datapath, evaluated for whichever
// channel currently holds the grant.
// Ports:
//   state_i       current detector state of the granted channel
//   bit_i         serial bit being consumed
//   next_state_o  state to write back for that channel
//   hit_o         Mealy output: this bit completes the pattern
// -----------------------------------------------------------------------------
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter logic [3:0] PATTERN = PATTERN_DEFAULT
) (
  input  det_state_e state_i,
  input  logic       bit_i,
  output det_state_e next_state_o,
  output logic       hit_o
);

  det_step_t step;

  always_comb begin
    step = det_next(state_i, bit_i, PATTERN);
  end

  assign next_state_o = step.next_state;
  assign hit_o        = step.hit;

endmodule

// File: rtl/seq_det_sched.sv
// -----------------------------------------------------------------------------
// seq_det_sched
// Shares one overlapping Mealy sequence detector across N serial streams.
// A round-robin arbiter consumes at most one bit per cycle; per-channel
// detector state and saturating hit counters live in register arrays.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req[N]        channel has a valid bit on bits[i], held until ack[i]
//   bits[N]       serial data bit per channel
//   clr[N]        synchronous per-channel clear of state and hit counter
//   ack[N]        one-hot-or-zero grant, combinational
//   det_valid     registered: a bit was consumed in the previous cycle
//   det_ch        registered: channel of that bit
//   det_hit       registered: that bit completed the pattern
//   rd_sel        hit-counter read select
//   rd_cnt        combinational hit_cnt[rd_sel], 0 when out of range
// -----------------------------------------------------------------------------
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter  int         N       = 4,
  parameter  logic [3:0] PATTERN = PATTERN_DEFAULT,
  parameter  int         CNT_W   = 8,
  localparam int         CW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     bits,
  input  logic [N-1:0]     clr,
  output logic [N-1:0]     ack,
  output logic             det_valid,
  output logic [CW-1:0]    det_ch,
  output logic             det_hit,
  input  logic [CW-1:0]    rd_sel,
  output logic [CNT_W-1:0] rd_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  det_state_e       state_q   [N];
  logic [CNT_W-1:0] hit_cnt_q [N];
  logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             det_valid_q;
  logic [CW-1:0]    det_ch_q;
  logic             det_hit_q;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [N-1:0]  elig;
  logic          gnt_vld;
  logic [CW-1:0] gnt_idx;

  // A channel being cleared must not be consumed in the same cycle.
  assign elig = req & ~clr;

  // NOTE: every combinational output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      int            pos;
      logic [CW-1:0] cand;
      pos = int'(rr_ptr_q) + i;
      if (pos >= N) pos = pos - N;
      cand = CW'(pos);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (gnt_vld && !rst) ack[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared detector, fed with the granted channel's state
  // ---------------------------------------------------------------------------
  det_state_e cur_state;
  det_state_e core_next;
  logic       core_hit;

  assign cur_state = state_q[gnt_idx];

  seq_det_core #(
    .PATTERN (PATTERN)
  ) u_core (
    .state_i      (cur_state),
    .bit_i        (bits[gnt_idx]),
    .next_state_o (core_next),
    .hit_o        (core_hit)
  );

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  // NOTE: the state and counter arrays are reset explicitly; partial matches
  // and counts must not survive reset, so they cannot map to reset-less RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_hit_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        state_q[i]   <= S0;
        hit_cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      rr_ptr_q    <= rr_ptr_d;
      det_valid_q <= gnt_vld;
      if (gnt_vld) begin
        det_ch_q  <= gnt_idx;
        det_hit_q <= core_hit;
      end
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin
          // Clear wins over any update to the same channel.
          state_q[i]   <= S0;
          hit_cnt_q[i] <= '0;
        end else if (gnt_vld && (gnt_idx == CW'(i))) begin
          state_q[i] <= core_next;
          if (core_hit && (hit_cnt_q[i] != '1)) begin
            hit_cnt_q[i] <= hit_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign det_hit   = det_hit_q;

  // Select values beyond N-1 exist only when N is not a power of two.
  always_comb begin
    rd_cnt = '0;
    if (int'(rd_sel) < N) rd_cnt = hit_cnt_q[rd_sel];
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_det_sched
// Scoreboard bench: the driver pushes the hand-computed detector response
// when it sees a bit acked; the monitor pops and compares on det_valid.
// Counter width is reduced to 2 bits so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_seq_det_sched;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     bits;
  logic [N-1:0]     clr;
  logic [N-1:0]     ack;
  logic             det_valid;
  logic [CW-1:0]    det_ch;
  logic             det_hit;
  logic [CW-1:0]    rd_sel;
  logic [CNT_W-1:0] rd_cnt;

  seq_det_sched #(
    .N       (N),
    .PATTERN (4'b1101),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bits      (bits),
    .clr       (clr),
    .ack       (ack),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .det_hit   (det_hit),
    .rd_sel    (rd_sel),
    .rd_cnt    (rd_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int   ch;
    logic hit;
    int   cyc;
  } exp_t;

  exp_t sb_q[$];

  always @(negedge clk) begin
    if (!rst && det_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_det_valid", 32'(det_valid), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("det_ch",      32'(det_ch),  32'(e.ch));
        check("det_hit",     32'(det_hit), 32'(e.hit));
        check("det_latency", 32'(cyc),     32'(e.cyc));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers; the main thread is parked at posedge+1 between steps
  // ---------------------------------------------------------------------------
  task automatic send(input logic [1:0] ch, input logic b, input logic exp_hit);
    bit got;
    got      = 1'b0;
    req[ch]  = 1'b1;
    bits[ch] = b;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack[ch]) begin
        sb_q.push_back('{ch: int'(ch), hit: exp_hit, cyc: cyc + 1});
        got = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    if (!got) begin
      check("ack_timeout", 32'(0), 32'(1));
      @(posedge clk);
      #1;
    end
    req[ch] = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic check_cnt(input string name, input logic [1:0] sel, input int exp);
    rd_sel = sel;
    #1;
    check(name, 32'(rd_cnt), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0]  pat4;
    logic [15:0] s6;
    int          idx1, idx2, hits;

    // 1: reset, requests held during reset must not be acked
    rst    = 1'b1;
    req    = '1;
    bits   = '0;
    clr    = '0;
    rd_sel = '0;
    #2;
    check("rst_ack",       32'(ack),       32'(0));
    check("rst_det_valid", 32'(det_valid), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    req = '0;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_ack",       32'(ack),       32'(0));
      check("idle_det_valid", 32'(det_valid), 32'(0));
    end
    for (int s = 0; s < N; s++) check_cnt("idle_rd_cnt", 2'(s), 0);
    @(posedge clk);
    #1;

    // 3: all four requesting, round-robin from pointer 0
    req  = 4'b1111;
    bits = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_ack", 32'(ack), 32'(4'b0001 << k[1:0]));
      sb_q.push_back('{ch: k % 4, hit: 1'b0, cyc: cyc + 1});
    end
    @(posedge clk);
    #1;
    req = '0;
    drain();

    // 2: channel 0 alone, overlapping hits on 4th and 7th bit
    send(2'd0, 1'b1, 1'b0);
    send(2'd0, 1'b1, 1'b0);
    send(2'd0, 1'b0, 1'b0);
    send(2'd0, 1'b1, 1'b1);
    send(2'd0, 1'b1, 1'b0);
    send(2'd0, 1'b0, 1'b0);
    send(2'd0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("hold_det_valid", 32'(det_valid), 32'(0));
    check("hold_det_ch",    32'(det_ch),    32'(0));
    check("hold_det_hit",   32'(det_hit),   32'(1));
    check_cnt("ch0_cnt_overlap", 2'd0, 2);
    @(posedge clk);
    #1;

    // 4: channels 1 and 2 interleave 1101 each
    pat4 = 4'b1101;
    idx1 = 0;
    idx2 = 0;
    req  = 4'b0110;
    bits = {1'b0, pat4[3], pat4[3], 1'b0};
    for (int n = 0; n < 20 && (idx1 < 4 || idx2 < 4); n++) begin
      @(negedge clk);
      check("interleave_ack_range", 32'(ack & 4'b1001), 32'(0));
      if (ack[1]) begin
        sb_q.push_back('{ch: 1, hit: (idx1 == 3), cyc: cyc + 1});
        idx1++;
      end
      if (ack[2]) begin
        sb_q.push_back('{ch: 2, hit: (idx2 == 3), cyc: cyc + 1});
        idx2++;
      end
      @(posedge clk);
      #1;
      req[1]  = (idx1 < 4);
      req[2]  = (idx2 < 4);
      bits[1] = (idx1 < 4) ? pat4[2'(3 - idx1)] : 1'b0;
      bits[2] = (idx2 < 4) ? pat4[2'(3 - idx2)] : 1'b0;
    end
    req  = '0;
    bits = '0;
    drain();
    check_cnt("ch1_cnt", 2'd1, 1);
    check_cnt("ch2_cnt", 2'd2, 1);

    // 5: clear on channel 3 blocks the ack and wipes state and counter
    send(2'd3, 1'b1, 1'b0);
    send(2'd3, 1'b1, 1'b0);
    send(2'd3, 1'b0, 1'b0);
    send(2'd3, 1'b1, 1'b1);
    send(2'd3, 1'b1, 1'b0);
    send(2'd3, 1'b0, 1'b0);
    drain();
    check_cnt("ch3_cnt_before_clr", 2'd3, 1);
    @(posedge clk);
    #1;
    clr[3]  = 1'b1;
    req[3]  = 1'b1;
    bits[3] = 1'b1;
    @(negedge clk);
    check("clr_no_ack", 32'(ack), 32'(0));
    @(posedge clk);
    #1;
    clr[3] = 1'b0;
    check_cnt("ch3_cnt_after_clr", 2'd3, 0);
    send(2'd3, 1'b1, 1'b0);
    drain();
    check_cnt("ch3_cnt_no_hit", 2'd3, 0);

    // 6: five hits on channel 0 saturate the 2-bit counter
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    s6     = 16'b1101101101101101;
    hits   = 0;
    for (int i = 0; i < 16; i++) begin
      logic h;
      h = (i >= 3) && (i % 3 == 0);
      send(2'd0, s6[4'(15 - i)], h);
      if (h) hits++;
      check_cnt("sat_cnt", 2'd0, (hits > 3) ? 3 : hits);
    end
    drain();

    // 6: reset while channel 0 holds a partial match and det_valid is high
    send(2'd0, 1'b1, 1'b0);
    send(2'd0, 1'b1, 1'b0);
    send(2'd2, 1'b0, 1'b0);
    req  = 4'b1111;
    bits = '0;
    rst  = 1'b1;
    #1;
    sb_q.delete();
    check("midrst_ack",       32'(ack),       32'(0));
    check("midrst_det_valid", 32'(det_valid), 32'(0));
    check("midrst_det_ch",    32'(det_ch),    32'(0));
    check("midrst_det_hit",   32'(det_hit),   32'(0));
    for (int s = 0; s < N; s++) check_cnt("midrst_rd_cnt", 2'(s), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_rr_ack", 32'(ack), 32'(4'b0001));
    sb_q.push_back('{ch: 0, hit: 1'b0, cyc: cyc + 1});
    @(posedge clk);
    #1;
    req = '0;
    // Without the reset this 1 would complete 1101 from the saved 11+0.
    send(2'd0, 1'b1, 1'b0);
    drain();
    check_cnt("postrst_ch0_cnt", 2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
